// File: rtl/shift_seq_pkg.sv
// Shared encodings and defaults for the shift-register command sequencer.
package shift_seq_pkg;

  localparam int unsigned DefWidth = 64;
  localparam int unsigned DefCntW  = 7;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/shift_sequencer.sv
// Command-driven sequencer that drives the load/shift pins of a downstream shift register
// one cycle at a time and reports completion with a done/done_err pulse.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             abort,
  output logic             load_en,
  output logic             shift_en,
  output logic             shift_dir,
  output logic             serial_in,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic             done_err,
  output logic [CNT_W-1:0] bits_left
);

  localparam logic [CNT_W-1:0] WidthCnt = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic             err_q, err_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] eff_len;
  op_e              op;

  assign op      = op_e'(cmd_op);
  assign eff_len = (cmd_len > WidthCnt) ? WidthCnt : cmd_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      dir_q   <= 1'b0;
      data_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          unique case (op)
            OP_LOAD:        state_d = StLoad;
            OP_SHL, OP_SHR: state_d = (eff_len != '0) ? StShift : StDone;
            OP_RSVD:        state_d = StDone;
          endcase
        end
      end
      StLoad:  state_d = StDone;
      // The current shift still completes when aborted; only the continuation is dropped.
      StShift: if (abort || cnt_q == CNT_W'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
    endcase
  end

  always_comb begin
    err_d  = err_q;
    dir_d  = dir_q;
    data_d = data_q;
    buf_d  = buf_q;
    cnt_d  = cnt_q;
    if (state_q == StIdle && cmd_valid) begin
      unique case (op)
        OP_LOAD: begin
          data_d = cmd_data;
          err_d  = 1'b0;
        end
        OP_SHL, OP_SHR: begin
          dir_d = cmd_op[1];
          buf_d = cmd_data;
          cnt_d = eff_len;
          err_d = 1'b0;
        end
        OP_RSVD: err_d = 1'b1;
      endcase
    end else if (state_q == StShift) begin
      buf_d = buf_q >> 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (abort) err_d = 1'b1;
    end
  end

  always_comb begin
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    load_en   = (state_q == StLoad);
    shift_en  = (state_q == StShift);
    serial_in = (state_q == StShift) & buf_q[0];
    done      = (state_q == StDone);
    done_err  = (state_q == StDone) & err_q;
    shift_dir = dir_q;
    data_in   = data_q;
    bits_left = cnt_q;
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against a command-level reference model.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [6:0]  cmd_len = '0;
  logic [63:0] cmd_data = '0;
  logic        abort = 1'b0;
  logic        load_en, shift_en, shift_dir, serial_in, busy, done, done_err;
  logic [63:0] data_in;
  logic [6:0]  bits_left;

  shift_sequencer #(.WIDTH(64), .CNT_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .load_en   (load_en),
    .shift_en  (shift_en),
    .shift_dir (shift_dir),
    .serial_in (serial_in),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .done_err  (done_err),
    .bits_left (bits_left)
  );

  always #5 clk = ~clk;

  // Downstream 64-bit shift register fed by the sequencer pins.
  logic [63:0] dn_q = '0;
  always @(posedge clk) begin
    if (load_en)       dn_q <= data_in;
    else if (shift_en) dn_q <= shift_dir ? {serial_in, dn_q[63:1]} : {dn_q[62:0], serial_in};
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: downstream register contents and held sequencer status.
  logic [63:0] mr  = '0;
  logic [63:0] mdi = '0;
  logic        md  = 1'b0;
  int          mb  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] shift_model(input logic [63:0] r, input logic [63:0] d,
                                              input int n, input logic dir);
    for (int i = 0; i < n; i++) r = dir ? {d[i], r[63:1]} : {r[62:0], d[i]};
    return r;
  endfunction

  // Issue one command at a negedge and observe it to completion; abort_at is a 1-based
  // shift-cycle index (0 = never).
  task automatic run_cmd(input logic [1:0] op, input int len, input logic [63:0] data,
                         input int abort_at);
    int eff, n, exp_done, exp_loads, loads, shifts, both, rdy_bad, dir_bad, ld_bad, done_k;
    logic exp_err, aborted, is_shift, err_seen;
    logic [63:0] obs_bits, mask;
    logic [6:0]  bl_seen;
    is_shift = (op == OP_SHL) || (op == OP_SHR);
    eff      = is_shift ? ((len > 64) ? 64 : len) : 0;
    aborted  = is_shift && abort_at >= 1 && abort_at <= eff;
    n        = aborted ? abort_at : eff;
    exp_loads = (op == OP_LOAD) ? 1 : 0;
    exp_err   = (op == OP_RSVD) || aborted;
    exp_done  = (op == OP_LOAD) ? 2 : n + 1;
    mask      = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);

    check("ready_before", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = 7'(len);
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = ~data;
    cmd_len   = 7'($urandom_range(0, 127));

    loads = 0; shifts = 0; both = 0; rdy_bad = 0; dir_bad = 0; ld_bad = 0; done_k = 0;
    err_seen = 1'b0; bl_seen = '0; obs_bits = '0;
    for (int k = 1; k <= 200 && done_k == 0; k++) begin
      if (shift_en) begin
        if (shifts < 64) obs_bits[shifts] = serial_in;
        shifts++;
        if (shift_dir !== op[1]) dir_bad++;
      end
      if (load_en) begin
        loads++;
        if (data_in !== data) ld_bad++;
      end
      if (load_en && shift_en) both++;
      if (cmd_ready === busy || cmd_ready !== 1'b0) rdy_bad++;
      if (done) begin
        done_k   = k;
        err_seen = done_err;
        bl_seen  = bits_left;
      end else begin
        abort = (k == abort_at);
        @(negedge clk);
        abort = 1'b0;
      end
    end

    if (op == OP_LOAD) begin
      mr  = data;
      mdi = data;
    end else if (is_shift) begin
      md = op[1];
      mb = eff - n;
      mr = shift_model(mr, data, n, op[1]);
    end

    check("done_latency", 64'(done_k), 64'(exp_done));
    check("done_err", {63'd0, err_seen}, {63'd0, exp_err});
    check("load_cycles", 64'(loads), 64'(exp_loads));
    check("shift_cycles", 64'(shifts), 64'(n));
    check("serial_bits", obs_bits, data & mask);
    check("bits_left_at_done", {57'd0, bl_seen}, 64'(mb));
    check("load_shift_overlap", 64'(both), 64'd0);
    check("ready_busy", 64'(rdy_bad), 64'd0);
    check("dir_during_shift", 64'(dir_bad), 64'd0);
    check("data_in_at_load", 64'(ld_bad), 64'd0);
    @(negedge clk);
    check("ready_after", {63'd0, cmd_ready}, 64'd1);
    check("idle_pins", {61'd0, load_en, shift_en, done}, 64'd0);
    check("shift_dir_hold", {63'd0, shift_dir}, {63'd0, md});
    check("data_in_hold", data_in, mdi);
    check("downstream_reg", dn_q, mr);
  endtask

  task automatic reset_mid_shift();
    int stray_done;
    cmd_valid = 1'b1;
    cmd_op    = OP_SHL;
    cmd_len   = 7'd30;
    cmd_data  = {$urandom, $urandom};
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_pre_shift_en", {63'd0, shift_en}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_shift_en", {63'd0, shift_en}, 64'd0);
    check("rst_async_ready_busy", {62'd0, cmd_ready, busy}, 64'd2);
    check("rst_async_bits_left", {57'd0, bits_left}, 64'd0);
    check("rst_async_dir_data", {data_in[62:0], shift_dir}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || shift_en) stray_done++;
    end
    check("rst_no_done", 64'(stray_done), 64'd0);
    mb  = 0;
    md  = 1'b0;
    mdi = '0;
  endtask

  initial begin
    #1;
    check("reset_ready_busy", {62'd0, cmd_ready, busy}, 64'd2);
    check("reset_pins", {58'd0, load_en, shift_en, shift_dir, serial_in, done, done_err}, 64'd0);
    check("reset_data_in", data_in, 64'd0);
    check("reset_bits_left", {57'd0, bits_left}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(OP_LOAD, 0, 64'hDEADBEEF_01234567, 1);
    run_cmd(OP_SHL, 4, 64'h0000_0000_0000_000B, 0);
    check("shl4_low_nibble", {60'd0, dn_q[3:0]}, 64'hD);
    run_cmd(OP_SHR, 100, {$urandom, $urandom}, 0);
    run_cmd(OP_SHL, 0, {$urandom, $urandom}, 0);
    run_cmd(OP_RSVD, 9, {$urandom, $urandom}, 0);
    run_cmd(OP_SHL, 20, {$urandom, $urandom}, 5);
    check("abort_bits_left", {57'd0, bits_left}, 64'd15);
    run_cmd(OP_SHR, 64, {$urandom, $urandom}, 64);

    reset_mid_shift();
    run_cmd(OP_LOAD, 3, {$urandom, $urandom}, 0);
    run_cmd(OP_SHR, 7, {$urandom, $urandom}, 0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      int len, ab;
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 127);
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 70) : 0;
      run_cmd(op, len, {$urandom, $urandom}, ab);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
